// File: rtl/md_unit_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer with HI/LO registers.
// Operands are latched at issue; the result commits to HI/LO after a fixed latency.
module md_unit_ctrl #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cancel,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [2:0] OP_MTHI = 3'd4;
    localparam logic [2:0] OP_MTLO = 3'd5;

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [31:0]   r_a, r_b, r_hi, r_lo;
    logic [1:0]    r_op;
    logic          r_done;

    logic          w_accept, w_md_start, w_commit;
    logic [CW-1:0] w_load;

    assign w_accept   = start && !cancel && (r_state == S_IDLE);
    assign w_md_start = w_accept && (op[2] == 1'b0);
    assign w_load     = op[1] ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);

    always_comb begin
        w_state_nxt = r_state;
        w_commit    = 1'b0;
        case (r_state)
            S_IDLE: if (w_md_start) w_state_nxt = S_RUN;
            S_RUN: begin
                if (cancel) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == CW'(1)) begin
                    w_state_nxt = S_IDLE;
                    w_commit    = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Multiply results
    logic signed [63:0] w_prod_s;
    logic [63:0]        w_prod_u;
    assign w_prod_s = $signed({{32{r_a[31]}}, r_a}) * $signed({{32{r_b[31]}}, r_b});
    assign w_prod_u = {32'd0, r_a} * {32'd0, r_b};

    // Signed divide done on magnitudes so 0x80000000 / -1 wraps to 0x80000000 naturally
    logic        w_sgn;
    logic [31:0] w_abs_a, w_abs_b, w_q_mag, w_r_mag, w_q, w_r;
    logic [31:0] w_res_hi, w_res_lo;
    assign w_sgn   = ~r_op[0];
    assign w_abs_a = (w_sgn && r_a[31]) ? (32'd0 - r_a) : r_a;
    assign w_abs_b = (w_sgn && r_b[31]) ? (32'd0 - r_b) : r_b;
    assign w_q_mag = (w_abs_b == 32'd0) ? 32'd0 : (w_abs_a / w_abs_b);
    assign w_r_mag = (w_abs_b == 32'd0) ? 32'd0 : (w_abs_a % w_abs_b);
    assign w_q     = (w_sgn && (r_a[31] ^ r_b[31])) ? (32'd0 - w_q_mag) : w_q_mag;
    assign w_r     = (w_sgn && r_a[31]) ? (32'd0 - w_r_mag) : w_r_mag;

    always_comb begin
        w_res_hi = 32'd0;
        w_res_lo = 32'd0;
        if (r_op[1]) begin
            if (r_b == 32'd0) begin
                w_res_hi = r_a;
                w_res_lo = 32'hFFFF_FFFF;
            end else begin
                w_res_hi = w_r;
                w_res_lo = w_q;
            end
        end else if (r_op[0]) begin
            {w_res_hi, w_res_lo} = w_prod_u;
        end else begin
            {w_res_hi, w_res_lo} = w_prod_s;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_commit;
            if (w_md_start) begin
                r_a   <= a;
                r_b   <= b;
                r_op  <= op[1:0];
                r_cnt <= w_load;
            end else if (r_state == S_RUN) begin
                r_cnt <= cancel ? '0 : r_cnt - CW'(1);
            end
            if (w_commit) begin
                r_hi <= w_res_hi;
                r_lo <= w_res_lo;
            end
            if (w_accept && op == OP_MTHI) r_hi <= a;
            if (w_accept && op == OP_MTLO) r_lo <= a;
        end
    end

    assign busy = (r_state == S_RUN);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_md_unit_ctrl.sv
// Directed self-checking bench for md_unit_ctrl (MUL_CYCLES=5, DIV_CYCLES=10).
module tb_md_unit_ctrl;

    logic        clk = 1'b0;
    logic        rst_n, start, cancel;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        busy, done;
    logic [31:0] hi, lo;

    int errs   = 0;
    int checks = 0;

    md_unit_ctrl #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .cancel(cancel), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    // Called at a negedge; issues for one edge and returns at the following negedge.
    task automatic issue(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv);
        start = 1'b1; op = o; a = av; b = bv;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts negedges with busy high; returns at the first negedge with busy low.
    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (busy === 1'b1 && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; cancel = 1'b0; op = 3'd0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errs++; $display("FAIL reset_done got=%0b exp=0", done); end
        checks++; if ({hi, lo} !== 64'd0) begin errs++; $display("FAIL reset_hilo got=%h_%h exp=0", hi, lo); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mult;
        int cyc;
        issue(3'd0, 32'hFFFF_FFFD, 32'd5);
        checks++; if ({hi, lo} !== 64'd0) begin errs++; $display("FAIL mult_hold got=%h_%h exp=0", hi, lo); end
        wait_idle(cyc);
        checks++; if (cyc != 5) begin errs++; $display("FAIL mult_latency got=%0d exp=5", cyc); end
        checks++; if (done !== 1'b1) begin errs++; $display("FAIL mult_done got=%0b exp=1", done); end
        checks++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFF1) begin
            errs++; $display("FAIL mult_result got=%h_%h exp=ffffffff_fffffff1", hi, lo); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errs++; $display("FAIL mult_done_pulse got=%0b exp=0", done); end
    endtask

    task automatic test_multu_div;
        int cyc;
        issue(3'd1, 32'hFFFF_FFFF, 32'd2);
        wait_idle(cyc);
        checks++; if (hi !== 32'h1 || lo !== 32'hFFFF_FFFE) begin
            errs++; $display("FAIL multu_result got=%h_%h exp=00000001_fffffffe", hi, lo); end
        @(negedge clk);
        issue(3'd2, 32'hFFFF_FFF9, 32'd2);
        wait_idle(cyc);
        checks++; if (cyc != 10) begin errs++; $display("FAIL div_latency got=%0d exp=10", cyc); end
        checks++; if (done !== 1'b1) begin errs++; $display("FAIL div_done got=%0b exp=1", done); end
        checks++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
            errs++; $display("FAIL div_result got=%h_%h exp=ffffffff_fffffffd", hi, lo); end
        @(negedge clk);
    endtask

    task automatic test_div_edges;
        int cyc;
        issue(3'd3, 32'd7, 32'd0);
        wait_idle(cyc);
        checks++; if (hi !== 32'd7 || lo !== 32'hFFFF_FFFF) begin
            errs++; $display("FAIL divu_by_zero got=%h_%h exp=00000007_ffffffff", hi, lo); end
        @(negedge clk);
        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle(cyc);
        checks++; if (hi !== 32'd0 || lo !== 32'h8000_0000) begin
            errs++; $display("FAIL div_overflow got=%h_%h exp=00000000_80000000", hi, lo); end
        @(negedge clk);
        issue(3'd3, 32'd100, 32'd7);
        wait_idle(cyc);
        checks++; if (hi !== 32'd2 || lo !== 32'd14) begin
            errs++; $display("FAIL divu_result got=%h_%h exp=00000002_0000000e", hi, lo); end
        @(negedge clk);
    endtask

    task automatic test_busy_drop;
        int cyc;
        issue(3'd0, 32'd3, 32'd4);        // now in busy cycle 1
        @(negedge clk);                   // busy cycle 2
        start = 1'b1; op = 3'd2; a = 32'd100; b = 32'd7;
        @(negedge clk);                   // busy cycle 3
        op = 3'd4; a = 32'h1234;
        @(negedge clk);                   // busy cycle 4
        start = 1'b0;
        wait_idle(cyc);
        checks++; if (cyc + 3 != 5) begin errs++; $display("FAIL drop_latency got=%0d exp=5", cyc + 3); end
        checks++; if (hi !== 32'd0 || lo !== 32'd12) begin
            errs++; $display("FAIL drop_result got=%h_%h exp=00000000_0000000c", hi, lo); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errs++; $display("FAIL drop_no_queue got=%0b exp=0", busy); end
    endtask

    task automatic test_mt_and_cancel;
        int seen;
        issue(3'd4, 32'h11, 32'd0);
        checks++; if (hi !== 32'h11 || busy !== 1'b0) begin
            errs++; $display("FAIL mthi got=%h busy=%0b exp=00000011 busy=0", hi, busy); end
        issue(3'd5, 32'h22, 32'd0);
        checks++; if (lo !== 32'h22) begin errs++; $display("FAIL mtlo got=%h exp=00000022", lo); end
        issue(3'd2, 32'd100, 32'd7);      // busy cycle 1
        repeat (3) @(negedge clk);        // busy cycle 4
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        checks++; if (busy !== 1'b0) begin errs++; $display("FAIL cancel_busy got=%0b exp=0", busy); end
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (done === 1'b1) seen++;
            @(negedge clk);
        end
        checks++; if (seen != 0) begin errs++; $display("FAIL cancel_no_done got=%0d exp=0", seen); end
        checks++; if (hi !== 32'h11 || lo !== 32'h22) begin
            errs++; $display("FAIL cancel_hilo got=%h_%h exp=00000011_00000022", hi, lo); end
    endtask

    task automatic test_cancel_edges;
        cancel = 1'b1;
        issue(3'd5, 32'h99, 32'd0);
        checks++; if (lo !== 32'h22) begin errs++; $display("FAIL cancel_idle_mtlo got=%h exp=00000022", lo); end
        issue(3'd0, 32'd2, 32'd2);
        checks++; if (busy !== 1'b0) begin errs++; $display("FAIL cancel_idle_start got=%0b exp=0", busy); end
        cancel = 1'b0;
        issue(3'd0, 32'd9, 32'd9);        // busy cycle 1
        repeat (4) @(negedge clk);        // busy cycle 5, next edge is commit
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin
            errs++; $display("FAIL cancel_commit got busy=%0b done=%0b exp=0/0", busy, done); end
        checks++; if (hi !== 32'h11 || lo !== 32'h22) begin
            errs++; $display("FAIL cancel_commit_hilo got=%h_%h exp=00000011_00000022", hi, lo); end
        issue(3'd5, 32'hCAFE, 32'd0);
        checks++; if (lo !== 32'hCAFE || busy !== 1'b0 || done !== 1'b0) begin
            errs++; $display("FAIL mtlo_cafe got=%h busy=%0b done=%0b exp=0000cafe 0 0", lo, busy, done); end
    endtask

    task automatic test_back_to_back;
        int cyc;
        issue(3'd0, 32'd2, 32'd3);
        wait_idle(cyc);
        checks++; if (done !== 1'b1 || lo !== 32'd6) begin
            errs++; $display("FAIL b2b_first got done=%0b lo=%h exp=1 00000006", done, lo); end
        issue(3'd1, 32'h10, 32'h10);
        checks++; if (busy !== 1'b1 || done !== 1'b0) begin
            errs++; $display("FAIL b2b_accept got busy=%0b done=%0b exp=1/0", busy, done); end
        wait_idle(cyc);
        checks++; if (cyc != 5 || hi !== 32'd0 || lo !== 32'h100) begin
            errs++; $display("FAIL b2b_second got cyc=%0d %h_%h exp=5 00000000_00000100", cyc, hi, lo); end
        @(negedge clk);
    endtask

    task automatic test_reset_run;
        issue(3'd2, 32'd50, 32'd3);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin
            errs++; $display("FAIL reset_run_ctl got busy=%0b done=%0b exp=0/0", busy, done); end
        checks++; if ({hi, lo} !== 64'd0) begin errs++; $display("FAIL reset_run_hilo got=%h_%h exp=0", hi, lo); end
        repeat (12) @(negedge clk);
        checks++; if (done !== 1'b0 || {hi, lo} !== 64'd0) begin
            errs++; $display("FAIL reset_run_late got done=%0b %h_%h exp=0", done, hi, lo); end
    endtask

    initial begin
        @(negedge clk);
        test_reset;
        test_mult;
        test_multu_div;
        test_div_edges;
        test_busy_drop;
        test_mt_and_cancel;
        test_cancel_edges;
        test_back_to_back;
        test_reset_run;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
